// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide unit:
// operation encodings, the control state set and small operation classifiers.
package muldiv_pkg;

    // Operation codes as presented on the Op port.
    typedef enum logic [2:0] {
        OP_MULTU = 3'b000,
        OP_MULT  = 3'b001,
        OP_DIVU  = 3'b010,
        OP_DIV   = 3'b011,
        OP_MADDU = 3'b100,
        OP_MADD  = 3'b101,
        OP_MSUBU = 3'b110,
        OP_MSUB  = 3'b111
    } op_e;

    // Control sequence of one operation.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } state_e;

    // True for the two divide operations.
    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

    // True when operands are two's-complement and results need sign fix-up.
    function automatic logic op_is_signed(input op_e op);
        return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    endfunction

    // True when the product is folded into the existing {HI,LO}.
    function automatic logic op_is_acc(input op_e op);
        return op inside {OP_MADDU, OP_MADD, OP_MSUBU, OP_MSUB};
    endfunction

    // True when the product is subtracted from {HI,LO}.
    function automatic logic op_is_sub(input op_e op);
        return (op == OP_MSUBU) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/muldiv_divstep.sv
// One restoring-division step: bring the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and report the quotient bit.
module muldiv_divstep
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    // Trial value is one bit wider than the remainder so the shift never loses data.
    logic [WIDTH+1:0] trial;

    // Trial subtract and restore.
    always_comb begin
        // NOTE: combinational blocks use blocking (=) so each line sees the
        // value computed just above it; clocked blocks use <= so every flop
        // samples the pre-edge values of its neighbours.
        trial   = {rem_in, next_bit};
        q_bit   = (trial >= {2'b00, divisor});
        rem_out = q_bit ? (WIDTH+1)'(trial - {2'b00, divisor}) : trial[WIDTH:0];
    end

endmodule

// File: rtl/muldiv_iter.sv
// Multi-cycle HI/LO multiply/divide unit. A radix-2 engine handles one
// operand bit per cycle: shift-add for multiply, restoring for divide.
// Signed operations run on magnitudes and are sign-corrected in the final cycle.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [2:0]       Op,
    input  logic             Start,
    input  logic             We,
    input  logic             HiLo,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    // Control.
    state_e             state_q;
    state_e             state_d;
    logic               accept;
    logic [CNT_W-1:0]   cnt_q;

    // Operation captured at Start.
    op_e                op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;

    // Engine state.
    logic [WIDTH-1:0]   mag_a_q;     // multiplicand / dividend magnitude
    logic [WIDTH-1:0]   mag_b_q;     // divisor magnitude
    logic [2*WIDTH-1:0] acc_q;       // multiply accumulator; low half is dividend/quotient on divide
    logic [WIDTH:0]     rem_q;       // divide partial remainder
    logic               neg_res_q;   // negate product / quotient at the end
    logic               neg_rem_q;   // negate remainder at the end

    // Combinational helpers.
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_next;
    logic               q_bit;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] fix_val;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rmd;
    logic               fix_div_zero;

    // A Start only launches from IDLE, and loses to Flush and to a register write.
    assign accept = (state_q == IDLE) && Start && !We && !Flush;

    // Busy covers the Start cycle itself so the pipeline stalls without a bubble.
    assign Busy = (state_q != IDLE) || Start;

    // Operand magnitudes; MIN stays MIN, which reads correctly as unsigned.
    assign mag_a = (op_is_signed(op_q) && a_q[WIDTH-1]) ? -a_q : a_q;
    assign mag_b = (op_is_signed(op_q) && b_q[WIDTH-1]) ? -b_q : b_q;

    // Shift-add: add the multiplicand into the upper half when the multiplier LSB is set.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);

    muldiv_divstep #(
        .WIDTH (WIDTH)
    ) u_divstep (
        .rem_in   (rem_q),
        .next_bit (acc_q[WIDTH-1]),
        .divisor  (mag_b_q),
        .rem_out  (rem_next),
        .q_bit    (q_bit)
    );

    // Final-cycle result: sign correction, accumulate, divide-by-zero override.
    always_comb begin
        prod         = neg_res_q ? -acc_q : acc_q;
        quo          = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rmd          = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        fix_val      = prod;
        fix_div_zero = 1'b0;
        if (op_is_div(op_q)) begin
            if (mag_b_q == '0) begin
                fix_val      = {a_q, {WIDTH{1'b1}}};
                fix_div_zero = 1'b1;
            end else begin
                fix_val = {rmd, quo};
            end
        end else if (op_is_sub(op_q)) begin
            fix_val = {HI, LO} - prod;
        end else if (op_is_acc(op_q)) begin
            fix_val = {HI, LO} + prod;
        end
    end

    // State register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Flush returns to IDLE from anywhere.
    always_comb begin
        // NOTE: state_d gets its default before any branch, so no path leaves
        // it unassigned and no latch is inferred.
        state_d = state_q;
        if (Flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = PREP;
                PREP:    state_d = ITER;
                ITER:    if (cnt_q == CNT_W'(1)) state_d = FIX;
                FIX:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath, HI/LO and status flags.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            // NOTE: every datapath flop is in the async reset; there is no RAM
            // array here, so nothing is left holding stale data after Rst.
            op_q      <= OP_MULTU;
            a_q       <= '0;
            b_q       <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            HI        <= '0;
            LO        <= '0;
            Done      <= 1'b0;
            DivZero   <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (!Flush) begin
                // mthi/mtlo takes effect at once, even while an operation runs.
                if (We) begin
                    if (HiLo) begin
                        HI <= D1;
                    end else begin
                        LO <= D1;
                    end
                end

                case (state_q)
                    IDLE: begin
                        if (accept) begin
                            op_q    <= op_e'(Op);
                            a_q     <= D1;
                            b_q     <= D2;
                            DivZero <= 1'b0;
                        end
                    end
                    PREP: begin
                        mag_a_q   <= mag_a;
                        mag_b_q   <= mag_b;
                        neg_res_q <= op_is_signed(op_q) && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                        neg_rem_q <= op_is_signed(op_q) && a_q[WIDTH-1];
                        acc_q     <= op_is_div(op_q) ? {{WIDTH{1'b0}}, mag_a}
                                                     : {{WIDTH{1'b0}}, mag_b};
                        rem_q     <= '0;
                        cnt_q     <= CNT_W'(WIDTH);
                    end
                    ITER: begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (op_is_div(op_q)) begin
                            acc_q <= {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], q_bit};
                            rem_q <= rem_next;
                        end else begin
                            acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
                        end
                    end
                    FIX: begin
                        // A register write landing on this same edge is kept
                        // in place of the result.
                        if (!We) begin
                            HI <= fix_val[2*WIDTH-1:WIDTH];
                            LO <= fix_val[WIDTH-1:0];
                        end
                        if (fix_div_zero) begin
                            DivZero <= 1'b1;
                        end
                        Done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: directed cases with literal results, then random
// traffic checked every cycle against a cycle-count reference model.
module tb_muldiv_iter;
    import muldiv_pkg::*;

    localparam int WIDTH = 32;

    logic             Clk = 1'b0;
    logic             Rst = 1'b1;
    logic [WIDTH-1:0] D1 = '0;
    logic [WIDTH-1:0] D2 = '0;
    logic [2:0]       Op = '0;
    logic             Start = 1'b0;
    logic             We = 1'b0;
    logic             HiLo = 1'b0;
    logic             Flush = 1'b0;
    logic             Busy;
    logic             Done;
    logic             DivZero;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    always #5 Clk = ~Clk;

    muldiv_iter #(.WIDTH(WIDTH)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .D1      (D1),
        .D2      (D2),
        .Op      (Op),
        .Start   (Start),
        .We      (We),
        .HiLo    (HiLo),
        .Flush   (Flush),
        .Busy    (Busy),
        .Done    (Done),
        .DivZero (DivZero),
        .HI      (HI),
        .LO      (LO)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference arithmetic on 64-bit values.
    function automatic logic [63:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [63:0] hilo);
        logic signed [63:0] sa, sb, sq, sr;
        logic [63:0] up, sp;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        up = {32'h0, a} * {32'h0, b};
        sp = sa * sb;
        case (op)
            3'd0: return up;
            3'd1: return sp;
            3'd2, 3'd3: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (op == 3'd2) return {a % b, a / b};
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            3'd4: return hilo + up;
            3'd5: return hilo + sp;
            3'd6: return hilo - up;
            default: return hilo - sp;
        endcase
    endfunction

    // Reference model: an operation occupies WIDTH+2 edges after its Start edge.
    int          m_cyc  = 0;
    logic [2:0]  m_op   = '0;
    logic [31:0] m_a    = '0;
    logic [31:0] m_b    = '0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic        m_dz   = 1'b0;
    logic        m_done = 1'b0;

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            m_cyc  <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_dz   <= 1'b0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (Flush) begin
                m_cyc <= 0;
            end else begin
                if (We) begin
                    if (HiLo) m_hi <= D1;
                    else      m_lo <= D1;
                end
                if (m_cyc == 0) begin
                    if (Start && !We) begin
                        m_op  <= Op;
                        m_a   <= D1;
                        m_b   <= D2;
                        m_dz  <= 1'b0;
                        m_cyc <= WIDTH + 2;
                    end
                end else begin
                    m_cyc <= m_cyc - 1;
                    if (m_cyc == 1) begin
                        {m_hi, m_lo} <= model_result(m_op, m_a, m_b, {m_hi, m_lo});
                        if ((m_op == 3'd2 || m_op == 3'd3) && m_b == 32'h0) m_dz <= 1'b1;
                        m_done <= 1'b1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge Clk) begin
        if (!Rst && cmp_en) begin
            check("busy",    Busy,    (m_cyc != 0) || Start);
            check("done",    Done,    m_done);
            check("divzero", DivZero, m_dz);
            check("hi",      HI,      m_hi);
            check("lo",      LO,      m_lo);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Present Start for one edge; returns #1 after the Start edge.
    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Op = op; D1 = a; D2 = b; Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    // Launch and wait for the edge that writes HI/LO.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        launch(op, a, b);
        repeat (WIDTH + 2) tick();
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic        seen_done;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          mode, at;

        // Model pinned to hand-computed values.
        check("model_mult", model_result(3'd1, 32'hFFFF_FFF9, 32'd3, 64'h0), 64'hFFFF_FFFF_FFFF_FFEB);
        check("model_div",  model_result(3'd3, 32'hFFFF_FFF9, 32'd2, 64'h0), 64'hFFFF_FFFF_FFFF_FFFD);
        check("model_msub", model_result(3'd7, 32'hFFFF_FFFE, 32'd3, 64'h10), 64'd22);

        // Reset state while Rst is held.
        repeat (2) @(posedge Clk);
        #1;
        check("rst_hi", HI, 0);
        check("rst_lo", LO, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_divzero", DivZero, 0);
        Rst = 1'b0;
        cmp_en = 1'b1;
        tick();

        // MULTU max * max, with latency and Busy/Done shape.
        launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (WIDTH + 1) tick();
        check("multu_fix_busy", Busy, 1);
        check("multu_fix_done", Done, 0);
        tick();
        check("multu_hi", HI, 32'hFFFF_FFFE);
        check("multu_lo", LO, 32'h0000_0001);
        check("multu_done", Done, 1);
        check("multu_busy", Busy, 0);
        tick();
        check("multu_done_once", Done, 0);

        // Signed multiply then multiply-accumulate.
        run_op(OP_MULT, 32'hFFFF_FFF9, 32'd3);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFEB);
        run_op(OP_MADD, 32'd2, 32'd5);
        check("madd_hi", HI, 32'hFFFF_FFFF);
        check("madd_lo", LO, 32'hFFFF_FFF5);

        // Divides.
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);
        run_op(OP_DIVU, 32'd100, 32'd7);
        check("divu_lo", LO, 32'd14);
        check("divu_hi", HI, 32'd2);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("divmin_lo", LO, 32'h8000_0000);
        check("divmin_hi", HI, 32'h0);
        check("divmin_dz", DivZero, 0);
        run_op(OP_DIVU, 32'h1234, 32'h0);
        check("div0_hi", HI, 32'h1234);
        check("div0_lo", LO, 32'hFFFF_FFFF);
        check("div0_dz", DivZero, 1);

        // Next Start clears DivZero; Flush at cycle 10 aborts without a result.
        launch(OP_MULTU, 32'd9, 32'd9);
        check("dz_cleared", DivZero, 0);
        repeat (9) tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        check("flush_busy", Busy, 0);
        check("flush_hi", HI, 32'h1234);
        check("flush_lo", LO, 32'hFFFF_FFFF);
        seen_done = 1'b0;
        repeat (WIDTH + 4) begin
            tick();
            seen_done = seen_done | Done;
        end
        check("flush_no_done", seen_done, 0);

        // Start while busy is ignored.
        launch(OP_MULTU, 32'd3, 32'd5);
        repeat (5) tick();
        Op = OP_DIVU; D1 = 32'd100; D2 = 32'd7; Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (WIDTH + 2 - 6) tick();
        check("ignore_hi", HI, 32'd0);
        check("ignore_lo", LO, 32'd15);
        check("ignore_done", Done, 1);

        // mtlo during the operation, then overwritten by the result.
        launch(OP_MULTU, 32'd6, 32'd7);
        repeat (9) tick();
        We = 1'b1; HiLo = 1'b0; D1 = 32'h55;
        tick();
        We = 1'b0;
        check("mtlo_now", LO, 32'h55);
        repeat (WIDTH + 2 - 10) tick();
        check("mtlo_over_lo", LO, 32'd42);
        check("mtlo_over_hi", HI, 32'd0);

        // Asynchronous reset in the middle of the iteration.
        launch(OP_MULTU, 32'hFFFF_FFFF, 32'd3);
        repeat (10) tick();
        #2;
        Rst = 1'b1;
        #1;
        check("arst_hi", HI, 0);
        check("arst_lo", LO, 0);
        check("arst_busy", Busy, 0);
        Rst = 1'b0;
        tick();

        // Random traffic with occasional register writes, ignored Starts and flushes.
        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = rand_operand();
            rb  = rand_operand();
            if ($urandom_range(0, 15) == 0) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            mode = int'($urandom_range(0, 9));
            at   = int'($urandom_range(1, WIDTH));
            Op = rop; D1 = ra; D2 = rb; Start = 1'b1;
            if (mode == 0) begin
                We   = 1'b1;
                HiLo = 1'($urandom_range(0, 1));
            end
            tick();
            Start = 1'b0;
            We    = 1'b0;
            for (int c = 1; c <= WIDTH + 2; c++) begin
                if (c == at) begin
                    case (mode)
                        1: begin
                            We   = 1'b1;
                            HiLo = 1'($urandom_range(0, 1));
                            D1   = 32'($urandom);
                        end
                        2: begin
                            Start = 1'b1;
                            Op    = 3'($urandom_range(0, 7));
                            D1    = 32'($urandom);
                            D2    = 32'($urandom);
                        end
                        3: Flush = 1'b1;
                        default: ;
                    endcase
                end
                tick();
                We    = 1'b0;
                Start = 1'b0;
                Flush = 1'b0;
            end
        end

        repeat (3) tick();
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
Parametrised multi-cycle HI/LO multiply/divide unit for the MIPS datapath EX stage; next generation of the current MUL/DIV block.
- Replaces the vendor multiplier/divider cores with an in-house iterative radix-2 engine: shift-add multiply, restoring divide.
- Adds multiply-accumulate/subtract, a divide-by-zero flag, a done pulse and a pipeline flush.
- HI/LO live here; mfhi/mflo read them directly; the pipeline stalls on Busy.

Parameters:
WIDTH, 32, operand and HI/LO width; any even value from 8 to 64.

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  reset, asynchronous, active-high
D1  in  WIDTH  operand A (dividend / multiplicand); also mthi/mtlo data
D2  in  WIDTH  operand B (divisor / multiplier)
Op  in  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MADDU, 101 MADD, 110 MSUBU, 111 MSUB
Start  in  1  launch Op on D1/D2, sampled at the rising edge
We  in  1  write D1 to HI/LO (mthi/mtlo)
HiLo  in  1  We target: 0 = LO, 1 = HI
Flush  in  1  abort the in-flight operation (exception/eret)
Busy  out  1  state != IDLE, or Start is asserted this cycle (combinational)
Done  out  1  one-cycle pulse in the cycle after HI/LO are updated
DivZero  out  1  sticky; set when a DIV/DIVU with D2 == 0 completes, cleared by the next Start
HI  out  WIDTH  HI register
LO  out  WIDTH  LO register

Behaviour:
- Reset (async): HI, LO, DivZero, Done = 0; FSM = IDLE; all internal registers = 0.
- Priority at each edge: Rst > Flush > We > Start > iteration.
- FSM states and transitions:
  - IDLE -> PREP on Start.
  - PREP -> ITER (1 cycle): for signed ops, take the magnitude of each operand; record product sign = sign(A)^sign(B), quotient sign = sign(A)^sign(B), remainder sign = sign(A).
  - ITER runs exactly WIDTH cycles on a log2(WIDTH)+1-bit counter, one bit per cycle. Multiply uses a 2*WIDTH accumulator. Divide keeps a WIDTH+1-bit partial remainder; a quotient bit is shifted in each cycle.
  - ITER -> FIX when the counter reaches 0.
  - FIX: apply sign correction. MADD*/MSUB* add/subtract the product to/from {HI,LO}, modulo 2^(2*WIDTH). Write HI/LO, then -> IDLE.
- Latency: Start sampled at edge E0 -> HI/LO written at edge E0+WIDTH+2 -> Done high for the cycle after that edge.
  - Busy is high from the Start cycle through the FIX cycle and low in the Done cycle.
- Results:
  - MULT*: {HI,LO} = full 2*WIDTH-bit product.
  - DIV*: LO = quotient, truncated toward zero; HI = remainder, carrying the dividend's sign.
- Divide by zero: ITER still runs full length; result HI = D1, LO = all ones; DivZero set.
- Signed MIN / -1: LO = MIN, HI = 0, no flag.
- Start while Busy (not Flush): ignored; Op, D1 and D2 are not re-latched.
- We while Busy: HI/LO are written immediately; the in-flight operation continues and its FIX overwrites them. MADD/MSUB read HI/LO at FIX, not at Start.
- We and Start in the same idle cycle: We is performed, Start is dropped.
- Flush: FSM -> IDLE at that edge; HI/LO and DivZero unchanged; no Done pulse. A Start in the same cycle as Flush is dropped.
- Rst mid-operation: full reset; no result is written.

Decomposition:
- muldiv_pkg holds:
  - op encodings OP_MULTU through OP_MSUB;
  - state enum IDLE/PREP/ITER/FIX;
  - helpers op_is_div, op_is_signed, op_is_acc, op_is_sub.
- One sub-module: muldiv_divstep. It is combinational and performs one restoring step (partial remainder, divisor -> next remainder, quotient bit), instantiated once.
- Multiply add-shift stays inline.

Test Plan:
- WIDTH=32, MULTU D1=0xFFFFFFFF, D2=0xFFFFFFFF -> after 34 edges HI=0xFFFFFFFE, LO=0x00000001; Done one cycle; Busy low in the Done cycle.
- MULT D1=-7, D2=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then MADD D1=2, D2=5 -> LO=0xFFFFFFF5, HI=0xFFFFFFFF.
- DIV D1=-7, D2=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU D1=100, D2=7 -> LO=14, HI=2. DIV D1=0x80000000, D2=-1 -> LO=0x80000000, HI=0, DivZero=0.
- DIVU D1=0x1234, D2=0 -> HI=0x1234, LO=0xFFFFFFFF, DivZero=1. Next Start clears DivZero.
- Start MULTU, assert Flush at cycle 10 -> Busy low the next cycle, HI/LO hold their prior values, no Done. A Start during Busy is ignored.
- Mid-op mtlo (We=1, HiLo=0, D1=0x55) -> LO=0x55 immediately, then overwritten at FIX. Rst pulsed mid-ITER -> HI=LO=0, Busy=0 asynchronously.
